// File: rtl/serial_lanes_link.sv
// rtl/serial_lanes_link.sv - multi-lane serial link, independent 8N1-style TX/RX per lane
// Optional feature: define SERIAL_LANES_LINK_LOOPBACK_EN to add loopback_i (TX->RX per lane, tx_o held high).
module serial_lanes_link #(
  parameter int LANES        = 2,
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
  input  logic                         loopback_i,
`endif
  input  logic [LANES-1:0][WIDTH-1:0]  tx_data_i,
  input  logic [LANES-1:0]             tx_valid_i,
  output logic [LANES-1:0]             tx_ready_o,
  output logic [LANES-1:0]             tx_o,
  input  logic [LANES-1:0]             rx_i,
  output logic [LANES-1:0][WIDTH-1:0]  rx_data_o,
  output logic [LANES-1:0]             rx_valid_o,
  output logic [LANES-1:0]             rx_frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [1:0]       r_tx_state;
    logic [CW-1:0]    r_tx_cnt;
    logic [BW-1:0]    r_tx_bit;
    logic [WIDTH-1:0] r_tx_shift;
    logic             w_tx_line;
    logic             w_rx_src;
    logic [1:0]       r_sync;
    logic             w_rx;
    logic [2:0]       r_rx_state;
    logic [CW-1:0]    r_rx_cnt;
    logic [BW-1:0]    r_rx_bit;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_err;

    // Transmitter: the word is latched on acceptance, so later tx_data_i changes cannot disturb the frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_tx_state <= TX_IDLE;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_shift <= '0;
      end else begin
        case (r_tx_state)
          TX_IDLE: begin
            if (tx_valid_i[g]) begin
              r_tx_shift <= tx_data_i[g];
              r_tx_cnt   <= '0;
              r_tx_state <= TX_START;
            end
          end
          TX_START: begin
            if (r_tx_cnt == C_LAST) begin
              r_tx_cnt   <= '0;
              r_tx_bit   <= '0;
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_cnt <= r_tx_cnt + CW'(1);
            end
          end
          TX_DATA: begin
            if (r_tx_cnt == C_LAST) begin
              r_tx_cnt   <= '0;
              r_tx_shift <= r_tx_shift >> 1;
              if (r_tx_bit == B_LAST) begin
                r_tx_state <= TX_STOP;
              end else begin
                r_tx_bit <= r_tx_bit + BW'(1);
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + CW'(1);
            end
          end
          TX_STOP: begin
            if (r_tx_cnt == C_LAST) begin
              r_tx_cnt   <= '0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_cnt <= r_tx_cnt + CW'(1);
            end
          end
          default: r_tx_state <= TX_IDLE;
        endcase
      end
    end

    always_comb begin
      w_tx_line = 1'b1;
      case (r_tx_state)
        TX_START: w_tx_line = 1'b0;
        TX_DATA:  w_tx_line = r_tx_shift[0];
        default:  w_tx_line = 1'b1;
      endcase
    end

    assign tx_ready_o[g] = (r_tx_state == TX_IDLE);

`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
    assign tx_o[g]  = loopback_i ? 1'b1 : w_tx_line;
    assign w_rx_src = loopback_i ? w_tx_line : rx_i[g];
`else
    assign tx_o[g]  = w_tx_line;
    assign w_rx_src = rx_i[g];
`endif

    // Idle-high reset value keeps a released reset from looking like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sync <= 2'b11;
      end else begin
        r_sync <= {r_sync[0], w_rx_src};
      end
    end

    assign w_rx = r_sync[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rx_state <= RX_IDLE;
        r_rx_cnt   <= '0;
        r_rx_bit   <= '0;
        r_rx_shift <= '0;
        r_rx_data  <= '0;
        r_rx_valid <= 1'b0;
        r_rx_err   <= 1'b0;
      end else begin
        r_rx_valid <= 1'b0;
        r_rx_err   <= 1'b0;
        case (r_rx_state)
          // Every path into IDLE leaves the line high, so a low level here is a 1->0 transition.
          RX_IDLE: begin
            if (!w_rx) begin
              r_rx_cnt   <= '0;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_rx_cnt == C_HALF) begin
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RX_DATA: begin
            if (r_rx_cnt == C_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= WIDTH'({w_rx, r_rx_shift} >> 1);
              if (r_rx_bit == B_LAST) begin
                r_rx_state <= RX_STOP;
              end else begin
                r_rx_bit <= r_rx_bit + BW'(1);
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RX_STOP: begin
            if (r_rx_cnt == C_LAST) begin
              r_rx_cnt <= '0;
              if (w_rx) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_rx_state <= RX_IDLE;
              end else begin
                r_rx_err   <= 1'b1;
                r_rx_state <= RX_BREAK;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RX_BREAK: begin
            if (!w_rx) begin
              r_rx_cnt <= '0;
            end else if (r_rx_cnt == C_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end

    assign rx_data_o[g]      = r_rx_data;
    assign rx_valid_o[g]     = r_rx_valid;
    assign rx_frame_err_o[g] = r_rx_err;
  end

endmodule

// File: tb/tb_serial_lanes_link.sv
// tb/tb_serial_lanes_link.sv - directed self-checking bench for serial_lanes_link
// Table of loopback-wired frames plus hand-written glitch, framing-error, reset and loopback sequences.
module tb_serial_lanes_link;
  localparam int LANES = 2;
  localparam int WIDTH = 8;
  localparam int CPB   = 16;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [LANES-1:0][WIDTH-1:0] tx_data_i;
  logic [LANES-1:0]            tx_valid_i;
  logic [LANES-1:0]            tx_ready_o;
  logic [LANES-1:0]            tx_o;
  logic [LANES-1:0]            rx_i;
  logic [LANES-1:0][WIDTH-1:0] rx_data_o;
  logic [LANES-1:0]            rx_valid_o;
  logic [LANES-1:0]            rx_frame_err_o;
  logic                        lb_wire;
  logic [LANES-1:0]            rx_drv;
`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
  logic                        loopback_i;
`endif

  assign rx_i = lb_wire ? tx_o : rx_drv;

  always #5 clk_i = ~clk_i;

  serial_lanes_link #(.LANES(LANES), .WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
    .loopback_i     (loopback_i),
`endif
    .tx_data_i      (tx_data_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .tx_o           (tx_o),
    .rx_i           (rx_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_frame_err_o (rx_frame_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt[LANES] = '{0, 0};
  int ecnt[LANES] = '{0, 0};
  int both_cnt = 0;

  always @(negedge clk_i) begin
    for (int l = 0; l < LANES; l++) begin
      if (rx_valid_o[l]) vcnt[l]++;
      if (rx_frame_err_o[l]) ecnt[l]++;
      if (rx_valid_o[l] && rx_frame_err_o[l]) both_cnt++;
    end
  end

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    int         ev0;
    int         ev1;
    logic [7:0] ed0;
    logic [7:0] ed1;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Sends one word and checks every cycle of the frame against {stop, data, start}.
  task automatic send_and_check(input int lane, input logic [7:0] word, input logic idle_other,
                                input logic expect_line);
    logic [9:0] bits;
    int bad;
    bits = {1'b1, word, 1'b0};
    tx_data_i[lane]  = word;
    tx_valid_i[lane] = 1'b1;
    tick();
    tx_valid_i[lane] = 1'b0;
    tx_data_i[lane]  = ~word;
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_o[lane] !== (expect_line ? bits[i] : 1'b1)) bad++;
        if (tx_ready_o[lane] !== 1'b0) bad++;
        if (idle_other && tx_o[1-lane] !== 1'b1) bad++;
        tick();
      end
      check($sformatf("tx_bit%0d_lane%0d_bad_cycles", i, lane), bad, 0);
    end
    check($sformatf("tx_ready_back_lane%0d", lane), tx_ready_o[lane], 1'b1);
  endtask

  task automatic drive_frame(input int lane, input logic [7:0] word, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, word, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv[lane] = bits[i];
      repeat (CPB) tick();
    end
    rx_drv[lane] = 1'b1;
  endtask

  initial begin
    int v0, v1, e0, e1;
    tx_data_i  = '0;
    tx_valid_i = '0;
    rx_drv     = '1;
    lb_wire    = 1'b1;
`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
    loopback_i = 1'b0;
`endif

    vt[0] = '{2'b11, 8'h3C, 8'hFF, 1, 1, 8'h3C, 8'hFF};
    vt[1] = '{2'b01, 8'hA5, 8'h00, 1, 0, 8'hA5, 8'hFF};
    vt[2] = '{2'b10, 8'h00, 8'h81, 0, 1, 8'hA5, 8'h81};
    vt[3] = '{2'b11, 8'h00, 8'h01, 1, 1, 8'h00, 8'h01};
    vt[4] = '{2'b11, 8'h80, 8'h7E, 1, 1, 8'h80, 8'h7E};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tx_o", tx_o, 2'b11);
    check("rst_tx_ready", tx_ready_o, 2'b11);
    check("rst_rx_valid", rx_valid_o, 2'b00);
    check("rst_rx_err", rx_frame_err_o, 2'b00);
    check("rst_rx_data", rx_data_o, 16'h0000);
    rst_ni = 1'b1;
    repeat (4) tick();

    // Lane0 0xA5 bit-by-bit, lane1 idle
    tick();
    send_and_check(0, 8'hA5, 1'b1, 1'b1);
    repeat (20) tick();
    check("a5_loop_data", rx_data_o[0], 8'hA5);

    for (int k = 0; k < 5; k++) begin
      v0 = vcnt[0]; v1 = vcnt[1]; e0 = ecnt[0]; e1 = ecnt[1];
      tx_data_i[0] = vt[k].d0;
      tx_data_i[1] = vt[k].d1;
      tx_valid_i   = vt[k].v;
      tick();
      tx_valid_i = '0;
      repeat (200) tick();
      check($sformatf("vec%0d_valid0", k), vcnt[0] - v0, vt[k].ev0);
      check($sformatf("vec%0d_valid1", k), vcnt[1] - v1, vt[k].ev1);
      check($sformatf("vec%0d_err", k), (ecnt[0] - e0) + (ecnt[1] - e1), 0);
      check($sformatf("vec%0d_data0", k), rx_data_o[0], vt[k].ed0);
      check($sformatf("vec%0d_data1", k), rx_data_o[1], vt[k].ed1);
    end

    // Glitch reject on lane1, then a real frame proves the receiver went back to IDLE
    lb_wire = 1'b0;
    rx_drv  = '1;
    repeat (4) tick();
    v1 = vcnt[1]; e1 = ecnt[1];
    rx_drv[1] = 1'b0;
    repeat (4) tick();
    rx_drv[1] = 1'b1;
    repeat (40) tick();
    check("glitch_valid", vcnt[1] - v1, 0);
    check("glitch_err", ecnt[1] - e1, 0);
    drive_frame(1, 8'h66, 1'b1);
    repeat (20) tick();
    check("post_glitch_valid", vcnt[1] - v1, 1);
    check("post_glitch_data", rx_data_o[1], 8'h66);

    // Framing error on lane0: line low through the stop bit, 16 high cycles, then 0x5A
    v0 = vcnt[0]; e0 = ecnt[0];
    drive_frame(0, 8'h00, 1'b0);
    repeat (CPB) tick();
    check("ferr_err_pulses", ecnt[0] - e0, 1);
    check("ferr_no_valid", vcnt[0] - v0, 0);
    check("ferr_data_kept", rx_data_o[0], 8'h80);
    drive_frame(0, 8'h5A, 1'b1);
    repeat (20) tick();
    check("after_break_valid", vcnt[0] - v0, 1);
    check("after_break_data", rx_data_o[0], 8'h5A);
    check("after_break_err", ecnt[0] - e0, 1);

    // Reset in the middle of data bit 4 of a looped-back frame
    lb_wire = 1'b1;
    repeat (4) tick();
    v0 = vcnt[0]; e0 = ecnt[0];
    tx_data_i[0]  = 8'hC3;
    tx_valid_i[0] = 1'b1;
    tick();
    tx_valid_i[0] = 1'b0;
    repeat (CPB * 5 + 8) tick();
    check("pre_rst_ready_low", tx_ready_o[0], 1'b0);
    rst_ni = 1'b0;
    #1;
    check("midrst_tx_o", tx_o, 2'b11);
    check("midrst_tx_ready", tx_ready_o, 2'b11);
    check("midrst_rx_data", rx_data_o, 16'h0000);
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (200) tick();
    check("post_rst_no_valid", vcnt[0] - v0, 0);
    check("post_rst_no_err", ecnt[0] - e0, 0);
    send_and_check(0, 8'h81, 1'b1, 1'b1);
    repeat (20) tick();
    check("post_rst_valid", vcnt[0] - v0, 1);
    check("post_rst_data", rx_data_o[0], 8'h81);

`ifdef SERIAL_LANES_LINK_LOOPBACK_EN
    lb_wire    = 1'b0;
    rx_drv     = '0;
    loopback_i = 1'b1;
    repeat (40) tick();
    v0 = vcnt[0]; v1 = vcnt[1]; e0 = ecnt[0];
    send_and_check(0, 8'h81, 1'b1, 1'b0);
    repeat (20) tick();
    check("lb_valid", vcnt[0] - v0, 1);
    check("lb_data", rx_data_o[0], 8'h81);
    check("lb_err", ecnt[0] - e0, 0);
    check("lb_lane1_quiet", vcnt[1] - v1, 0);
    loopback_i = 1'b0;
    rx_drv     = '1;
`endif

    check("valid_err_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
